// File: rtl/conv_pkg.sv
// Shared types and constants for the 3x3 convolution stage.
// Kernels pack nine signed 4-bit coefficients, coefficient k in bits [4k+3:4k].
package conv_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MAC  = 1'b1
    } state_t;

    localparam int PIX_W  = 8;
    localparam int COEF_W = 4;
    localparam int SUM_W  = 17;
    localparam int PROD_W = 13;
    localparam int N_TAPS = 9;
    localparam int KERN_W = COEF_W * N_TAPS;

    localparam logic [KERN_W-1:0] K_LAPLACE4 = 36'h0_F_0_F_4_F_0_F_0;
    localparam logic [KERN_W-1:0] K_SOBEL_X  = 36'h1_0_F_2_0_E_1_0_F;
    localparam logic [KERN_W-1:0] K_SOBEL_Y  = 36'h1_2_1_0_0_0_F_E_F;
    localparam logic [KERN_W-1:0] K_BOX      = 36'h1_1_1_1_1_1_1_1_1;

    function automatic logic signed [COEF_W-1:0] kernel_coef(
        input logic [KERN_W-1:0] kernel,
        input logic [3:0]        k
    );
        return kernel[COEF_W*k +: COEF_W];
    endfunction

endpackage

// File: rtl/conv3x3_sat_abs.sv
// Signed sum to 8-bit pixel: magnitude, right shift by SHIFT, clamp to 255.
module sat_abs
    import conv_pkg::*;
#(
    parameter int SHIFT = 0
) (
    input  logic signed [SUM_W-1:0] sum,
    output logic        [PIX_W-1:0] pix
);

    logic [SUM_W-1:0] mag_s;
    logic [SUM_W-1:0] shr_s;

    // Magnitude is taken at full sum width; -2^16 is unreachable for 3x3 windows.
    always_comb begin
        mag_s = {SUM_W{1'b0}};
        shr_s = {SUM_W{1'b0}};
        pix   = {PIX_W{1'b0}};
        if (sum[SUM_W-1]) begin
            mag_s = $unsigned(-sum);
        end else begin
            mag_s = $unsigned(sum);
        end
        shr_s = mag_s >> SHIFT;
        if (shr_s > {{(SUM_W-PIX_W){1'b0}}, {PIX_W{1'b1}}}) begin
            pix = {PIX_W{1'b1}};
        end else begin
            pix = shr_s[PIX_W-1:0];
        end
    end

endmodule

// File: rtl/conv3x3.sv
// 3x3 windowed convolution: snapshots a nine-byte window on i_recvd, then
// multiply-accumulates one kernel term per clock, producing a result every 9 cycles.
module conv3x3
    import conv_pkg::*;
#(
    parameter logic [KERN_W-1:0] KERNEL = K_LAPLACE4,
    parameter int                SHIFT  = 0
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic [N_TAPS-1:0][PIX_W-1:0]   i_mat,
    input  logic                           i_recvd,
    output logic [PIX_W-1:0]               o_pix,
    output logic signed [SUM_W-1:0]        o_sum,
    output logic                           o_valid,
    output logic                           o_busy,
    output logic                           o_overrun
);

    state_t                         state_r;
    logic [3:0]                     idx_r;
    logic signed [SUM_W-1:0]        acc_r;
    logic [N_TAPS-1:0][PIX_W-1:0]   win_r;

    logic [3:0]                     sel_s;
    logic [PIX_W-1:0]               tap_s;
    logic signed [COEF_W-1:0]       coef_s;
    logic signed [PROD_W-1:0]       prod_s;
    logic signed [SUM_W-1:0]        sum_s;
    logic [PIX_W-1:0]               pix_s;

    // Current term: unsigned window byte times signed coefficient, added to acc.
    always_comb begin
        sel_s  = 4'd0;
        tap_s  = {PIX_W{1'b0}};
        coef_s = {COEF_W{1'b0}};
        prod_s = {PROD_W{1'b0}};
        sum_s  = {SUM_W{1'b0}};
        if (idx_r > 4'd8) begin
            sel_s = 4'd8;
        end else begin
            sel_s = idx_r;
        end
        tap_s  = win_r[sel_s];
        coef_s = kernel_coef(KERNEL, sel_s);
        prod_s = PROD_W'($signed({1'b0, tap_s})) * PROD_W'(coef_s);
        sum_s  = acc_r + SUM_W'(prod_s);
    end

    sat_abs #(
        .SHIFT (SHIFT)
    ) u_sat_abs (
        .sum (sum_s),
        .pix (pix_s)
    );

    // Control FSM and MAC datapath; a window arriving on the final term is taken without a bubble.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r   <= ST_IDLE;
            idx_r     <= 4'd0;
            acc_r     <= {SUM_W{1'b0}};
            win_r     <= '0;
            o_pix     <= {PIX_W{1'b0}};
            o_sum     <= {SUM_W{1'b0}};
            o_valid   <= 1'b0;
            o_busy    <= 1'b0;
            o_overrun <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (i_recvd) begin
                        win_r   <= i_mat;
                        acc_r   <= {SUM_W{1'b0}};
                        idx_r   <= 4'd0;
                        state_r <= ST_MAC;
                        o_busy  <= 1'b1;
                    end
                end
                ST_MAC: begin
                    if (idx_r == 4'd8) begin
                        o_sum   <= sum_s;
                        o_pix   <= pix_s;
                        o_valid <= 1'b1;
                        acc_r   <= {SUM_W{1'b0}};
                        idx_r   <= 4'd0;
                        if (i_recvd) begin
                            win_r   <= i_mat;
                            state_r <= ST_MAC;
                            o_busy  <= 1'b1;
                        end else begin
                            state_r <= ST_IDLE;
                            o_busy  <= 1'b0;
                        end
                    end else begin
                        acc_r <= sum_s;
                        idx_r <= idx_r + 4'd1;
                        if (i_recvd) begin
                            o_overrun <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    idx_r   <= 4'd0;
                    acc_r   <= {SUM_W{1'b0}};
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv3x3.sv
// Scoreboard bench for conv3x3: expected results are queued at capture and
// matched against o_valid pulses (value and arrival cycle).
module tb_conv3x3;
    import conv_pkg::*;

    typedef logic [8:0][7:0] win_t;
    typedef struct packed {
        logic signed [16:0] sum;
        logic [7:0]         pix;
        logic [7:0]         pix2;
        logic [15:0]        cyc;
    } res_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    win_t               mat = '0;
    logic               recvd = 1'b0;
    logic [7:0]         o_pix, s2_pix;
    logic signed [16:0] o_sum, s2_sum;
    logic               o_valid, o_busy, o_overrun;
    logic               s2_valid, s2_busy, s2_overrun;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    res_t exp_q[$];
    res_t obs_q[$];
    res_t exp_v, obs_v;

    conv3x3 dut (
        .i_clk(clk), .i_rst(rst), .i_mat(mat), .i_recvd(recvd),
        .o_pix(o_pix), .o_sum(o_sum), .o_valid(o_valid), .o_busy(o_busy), .o_overrun(o_overrun)
    );

    conv3x3 #(.SHIFT(2)) dut_sh2 (
        .i_clk(clk), .i_rst(rst), .i_mat(mat), .i_recvd(recvd),
        .o_pix(s2_pix), .o_sum(s2_sum), .o_valid(s2_valid), .o_busy(s2_busy), .o_overrun(s2_overrun)
    );

    always #5 clk = ~clk;

    function automatic win_t make_win(input logic [7:0] c, input logic [7:0] n, input logic [7:0] o);
        win_t w;
        for (int k = 0; k < 9; k++) w[k] = o;
        w[1] = n; w[3] = n; w[5] = n; w[7] = n;
        w[4] = c;
        return w;
    endfunction

    function automatic res_t model(input win_t w, input int at);
        res_t r;
        logic [35:0] kv;
        logic signed [3:0] c;
        int s, a, p;
        kv = K_LAPLACE4;
        s = 0;
        for (int k = 0; k < 9; k++) begin
            c = kv[4*k +: 4];
            s += int'(w[k]) * int'(c);
        end
        a = (s < 0) ? -s : s;
        r.sum  = 17'(s);
        r.pix  = (a > 255) ? 8'd255 : 8'(a);
        p = a >> 2;
        r.pix2 = (p > 255) ? 8'd255 : 8'(p);
        r.cyc  = 16'(at);
        return r;
    endfunction

    task automatic tick();
        res_t r;
        @(posedge clk);
        #1;
        cyc++;
        if (o_valid) begin
            r.sum = o_sum; r.pix = o_pix; r.pix2 = s2_pix; r.cyc = 16'(cyc);
            obs_q.push_back(r);
        end
    endtask

    task automatic send(input win_t w);
        mat = w;
        recvd = 1'b1;
        tick();
        recvd = 1'b0;
        exp_q.push_back(model(w, cyc + 9));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ticks(2);
        checks++;
        if ({o_valid, o_busy, o_overrun, o_pix, o_sum} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b busy=%b ovr=%b pix=%0d sum=%0d, expected all 0",
                     o_valid, o_busy, o_overrun, o_pix, o_sum);
        end
        checks++;
        if ({s2_valid, s2_busy, s2_overrun, s2_pix, s2_sum} !== '0) begin
            errors++;
            $display("FAIL reset_outputs_sh2: got nonzero outputs on SHIFT=2 instance, expected all 0");
        end
        rst = 1'b0;
        ticks(2);
    endtask

    task automatic test_flat();
        int busy_n;
        send(make_win(8'd100, 8'd100, 8'd100));
        busy_n = o_busy ? 1 : 0;
        for (int i = 0; i < 11; i++) begin
            tick();
            if (o_busy) busy_n++;
        end
        checks++;
        if (busy_n !== 9) begin
            errors++;
            $display("FAIL flat_busy: got busy for %0d cycles, expected 9", busy_n);
        end
        while (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            obs_v = '0;
            if (obs_q.size() > 0) obs_v = obs_q.pop_front();
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL flat_result: got sum=%0d pix=%0d pix2=%0d cyc=%0d, expected sum=%0d pix=%0d pix2=%0d cyc=%0d",
                         obs_v.sum, obs_v.pix, obs_v.pix2, obs_v.cyc, exp_v.sum, exp_v.pix, exp_v.pix2, exp_v.cyc);
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL flat_extra_valid: got %0d extra o_valid pulses, expected 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_center_and_saturation();
        send(make_win(8'd50, 8'd0, 8'd0));
        ticks(12);
        send(make_win(8'd255, 8'd0, 8'd0));
        ticks(12);
        send(make_win(8'd0, 8'd255, 8'd0));
        ticks(12);
        while (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            obs_v = '0;
            if (obs_q.size() > 0) obs_v = obs_q.pop_front();
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL center_sat_result: got sum=%0d pix=%0d pix2=%0d cyc=%0d, expected sum=%0d pix=%0d pix2=%0d cyc=%0d",
                         obs_v.sum, obs_v.pix, obs_v.pix2, obs_v.cyc, exp_v.sum, exp_v.pix, exp_v.pix2, exp_v.cyc);
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL center_sat_extra_valid: got %0d extra o_valid pulses, expected 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_back_to_back();
        for (int w = 1; w <= 4; w++) begin
            send(make_win(8'(10 * w), 8'd0, 8'd0));
            if (w < 4) ticks(8);
        end
        ticks(12);
        while (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            obs_v = '0;
            if (obs_q.size() > 0) obs_v = obs_q.pop_front();
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL b2b_result: got sum=%0d pix=%0d pix2=%0d cyc=%0d, expected sum=%0d pix=%0d pix2=%0d cyc=%0d",
                         obs_v.sum, obs_v.pix, obs_v.pix2, obs_v.cyc, exp_v.sum, exp_v.pix, exp_v.pix2, exp_v.cyc);
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_extra_valid: got %0d extra o_valid pulses, expected 0", obs_q.size());
            obs_q.delete();
        end
        checks++;
        if (o_overrun !== 1'b0) begin
            errors++;
            $display("FAIL b2b_overrun: got o_overrun=%b, expected 0", o_overrun);
        end
    endtask

    task automatic test_overrun();
        send(make_win(8'd20, 8'd5, 8'd0));
        ticks(3);
        mat = make_win(8'd99, 8'd1, 8'd7);
        recvd = 1'b1;
        tick();
        recvd = 1'b0;
        checks++;
        if (o_overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_set: got o_overrun=%b, expected 1", o_overrun);
        end
        ticks(14);
        while (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            obs_v = '0;
            if (obs_q.size() > 0) obs_v = obs_q.pop_front();
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL overrun_result: got sum=%0d pix=%0d pix2=%0d cyc=%0d, expected sum=%0d pix=%0d pix2=%0d cyc=%0d",
                         obs_v.sum, obs_v.pix, obs_v.pix2, obs_v.cyc, exp_v.sum, exp_v.pix, exp_v.pix2, exp_v.cyc);
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL overrun_extra_valid: got %0d extra o_valid pulses, expected 0", obs_q.size());
            obs_q.delete();
        end
        checks++;
        if (o_overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_sticky: got o_overrun=%b, expected 1", o_overrun);
        end
    endtask

    task automatic test_reset_mid();
        send(make_win(8'd9, 8'd1, 8'd3));
        ticks(4);
        #3 rst = 1'b1;
        #1;
        checks++;
        if ({o_valid, o_busy, o_overrun, o_pix, o_sum} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: got valid=%b busy=%b ovr=%b pix=%0d sum=%0d, expected all 0",
                     o_valid, o_busy, o_overrun, o_pix, o_sum);
        end
        exp_q.delete();
        ticks(2);
        rst = 1'b0;
        ticks(12);
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL midreset_no_valid: got %0d o_valid pulses after reset, expected 0", obs_q.size());
            obs_q.delete();
        end
        send(make_win(8'd9, 8'd1, 8'd3));
        ticks(12);
        while (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            obs_v = '0;
            if (obs_q.size() > 0) obs_v = obs_q.pop_front();
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL midreset_result: got sum=%0d pix=%0d pix2=%0d cyc=%0d, expected sum=%0d pix=%0d pix2=%0d cyc=%0d",
                         obs_v.sum, obs_v.pix, obs_v.pix2, obs_v.cyc, exp_v.sum, exp_v.pix, exp_v.pix2, exp_v.cyc);
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL midreset_extra_valid: got %0d extra o_valid pulses, expected 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    initial begin
        test_reset();
        test_flat();
        test_center_and_saturation();
        test_back_to_back();
        test_overrun();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/conv3x3.md
# conv3x3

Windowed 3x3 convolution stage that consumes the nine-byte window produced by the upstream byte-collection buffer. When the buffer asserts its window-received strobe, this block snapshots all nine bytes. It then multiply-accumulates them against a fixed signed kernel, one term per clock. It emits a saturated 8-bit magnitude and the raw signed sum, and sustains one window every 9 cycles, which matches the buffer's refill rate.

## Interface
- KERNEL, 36'h0_F_0_F_4_F_0_F_0 (4-neighbour Laplacian): nine signed 4-bit coefficients; coefficient k is KERNEL[4k+3:4k] and multiplies window byte k.
- SHIFT, 0: right shift applied to |sum| before saturation, range 0..8.
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  reset, asynchronous and active-high.
- i_mat  in  8 x [9]  window bytes, unsigned, index 0..8, driven by the buffer's matrix output.
- i_recvd  in  1  window-complete strobe, driven by the buffer's received flag.
- o_pix  out  8  saturated output pixel, held until the next result.
- o_sum  out  17 signed  raw convolution sum, held until the next result.
- o_valid  out  1  one-cycle pulse; o_pix and o_sum are new this cycle.
- o_busy  out  1  high while a window is being accumulated.
- o_overrun  out  1  sticky; set when a window is dropped, cleared only by reset.

## Operation
- States are IDLE and MAC. A 4-bit term index idx runs 0..8. The accumulator acc is 17-bit signed.
- In IDLE, i_recvd=1 at an edge does three things: it copies i_mat[0..8] into an internal window register, it sets acc=0 and idx=0, and it moves the FSM to MAC.
- At each MAC edge, acc is updated to acc + zext9(win[idx]) * sext(coef[idx]). The product is 13-bit signed, extended to 17 bits. idx then increments.
- The MAC edge with idx==8 is the final term, and it does all of the following:
  - s = acc + last product.
  - o_sum <= s.
  - o_pix <= min(255, |s| >> SHIFT).
  - o_valid <= 1.
- On that idx==8 edge, if i_recvd=1, the new window is captured, acc and idx are cleared, and the FSM stays in MAC. Otherwise the FSM goes to IDLE.
- i_recvd=1 during MAC with idx 0..7 drops the new window and sets o_overrun. The in-flight computation is unaffected.
- o_busy is 1 exactly when state==MAC.
- Arithmetic: the worst-case |sum| is 9*255*8 = 18360, which fits in 17-bit signed without overflow. The absolute value is computed at 17 bits.
- Reset, asserted at any time and including mid-accumulation, takes effect immediately:
  - state=IDLE, acc=0, idx=0, window register=0.
  - o_pix=0, o_sum=0, o_valid=0, o_busy=0, o_overrun=0.
  - The in-flight window is discarded, and no o_valid follows for it.

## Timing
- Capture edge E0 is the edge where i_recvd=1 is accepted.
- MAC edges are E1..E9, and E9 registers the result. o_valid is high for exactly the one cycle following E9: latency is 9 clocks from capture.
- Throughput is one window per 9 clocks. i_recvd recurring exactly at E9 is accepted with no bubble.
- o_valid never stays high for two consecutive cycles unless results complete on consecutive edges, which cannot occur. o_valid is 0 in every other cycle.
- The window is snapshotted at E0, so upstream overwriting its storage from E1 onward has no effect on the result.

## Structure
- Shared package conv_pkg holds:
  - state encodings ST_IDLE and ST_MAC;
  - width constants PIX_W=8, COEF_W=4, SUM_W=17;
  - kernel constants K_LAPLACE4, K_SOBEL_X, K_SOBEL_Y and K_BOX.
- One sub-module, sat_abs: a combinational 17-bit signed to 8-bit converter covering abs, shift by SHIFT and clamp to 255, used at the final edge.
- The MAC datapath and FSM stay in conv3x3.

## Test plan
- Flat window, all bytes 100, default kernel, i_recvd pulsed once: o_valid high exactly 9 cycles after capture, o_sum=0, o_pix=0, and o_busy high for 9 cycles.
- Center byte 50, all others 0: o_sum=200, o_pix=200. With SHIFT=2, o_pix=50.
- Saturation in both signs:
  - center 255, all others 0: o_sum=1020, o_pix=255;
  - center 0, neighbours 1/3/5/7 = 255: o_sum=-1020, o_pix=255.
- Back-to-back: i_recvd every 9 cycles for 4 windows with distinct centers 10/20/30/40: four o_valid pulses 9 cycles apart, o_sum 40/80/120/160, o_overrun stays 0.
- Overrun: a second i_recvd 4 cycles after capture is dropped. The first result is correct, o_overrun=1 and stays set, and no second o_valid occurs.
- Reset asserted asynchronously at idx 4 (mid-MAC) for 2 cycles: all outputs read 0 immediately, no o_valid follows, and the next window after deassert computes correctly.
